// File: rtl/register_file.sv
// 32 x 32-bit RISC-V register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, optional write-to-read bypass.
module register_file #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    BYPASS     = 1,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    input  logic [ADDR_WIDTH-1:0] writeRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    // x0 has no storage; the array starts at index 1.
    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

    // A write only takes effect outside reset and never to x0.
    logic wr_fire;
    assign wr_fire = reset && regWrite && (writeRegister != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_fire) begin
            regs_d[writeRegister] = writeData;
        end
    end

    // NOTE: every register is reset (not just x2) so no read can ever return X;
    // sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 2) ? SP_RESET : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        readData1 = '0;
        if (readRegister1 != '0) begin
            if ((BYPASS != 0) && wr_fire && (readRegister1 == writeRegister)) begin
                readData1 = writeData;
            end else begin
                readData1 = regs_q[readRegister1];
            end
        end
    end

    always_comb begin
        readData2 = '0;
        if (readRegister2 != '0) begin
            if ((BYPASS != 0) && wr_fire && (readRegister2 == writeRegister)) begin
                readData2 = writeData;
            end else begin
                readData2 = regs_q[readRegister2];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one bypassing and one non-bypassing
// instance share the same stimulus; expected values are hand-computed.
module tb_register_file;

    localparam logic [31:0] SP = 32'h0000_FF00;

    logic        clock = 1'b0;
    logic        reset;
    logic        regWrite;
    logic [4:0]  readRegister1, readRegister2, writeRegister;
    logic [31:0] writeData;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1), .SP_RESET(SP)) dut_b (
        .clock(clock), .reset(reset), .regWrite(regWrite),
        .readRegister1(readRegister1), .readRegister2(readRegister2),
        .writeRegister(writeRegister), .writeData(writeData),
        .readData1(rd1_b), .readData2(rd2_b)
    );

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0), .SP_RESET(SP)) dut_n (
        .clock(clock), .reset(reset), .regWrite(regWrite),
        .readRegister1(readRegister1), .readRegister2(readRegister2),
        .writeRegister(writeRegister), .writeData(writeData),
        .readData1(rd1_n), .readData2(rd2_n)
    );

    // Small downstream ALU stand-in: registered add of the two operands.
    always_ff @(posedge clock) begin
        alu_result <= (alu_control == 4'b0010) ? rd1_b + rd2_b : 32'h0;
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        regWrite      = we;
        writeRegister = wr;
        writeData     = wd;
        readRegister1 = r1;
        readRegister2 = r2;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        alu_control = 4'b0000;
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd2);
        tick();
        #1;
        n_cmp++;
        if (rd1_b !== 32'h0) begin
            n_err++; $display("FAIL reset_bypass_suppressed: got %h want %h", rd1_b, 32'h0);
        end
        tick();
        reset = 1'b1;
        drive(1'b0, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd2);
        n_cmp++;
        if (rd1_b !== 32'h0) begin
            n_err++; $display("FAIL reset_x5: got %h want %h", rd1_b, 32'h0);
        end
        n_cmp++;
        if (rd2_b !== SP) begin
            n_err++; $display("FAIL reset_x2: got %h want %h", rd2_b, SP);
        end
        n_cmp++;
        if (rd1_n !== 32'h0 || rd2_n !== SP) begin
            n_err++; $display("FAIL reset_nobyp: got %h/%h want %h/%h", rd1_n, rd2_n, 32'h0, SP);
        end
        drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd0);
        n_cmp++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0) begin
            n_err++; $display("FAIL reset_x31_x0: got %h/%h want 0/0", rd1_b, rd2_b);
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 5'd7, 32'h0000_00A5, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd8, 32'hFFFF_FFFF, 5'd7, 5'd0);
        n_cmp++;
        if (rd1_b !== 32'h0000_00A5) begin
            n_err++; $display("FAIL wr_x7_during_x8: got %h want %h", rd1_b, 32'h0000_00A5);
        end
        tick();
        drive(1'b1, 5'd31, 32'h8000_0001, 5'd7, 5'd8);
        n_cmp++;
        if (rd1_b !== 32'h0000_00A5 || rd2_b !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL wr_x7_x8: got %h/%h want 000000a5/ffffffff", rd1_b, rd2_b);
        end
        n_cmp++;
        if (rd1_n !== 32'h0000_00A5 || rd2_n !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL wr_x7_x8_nobyp: got %h/%h want 000000a5/ffffffff", rd1_n, rd2_n);
        end
        tick();
        drive(1'b0, 5'd7, 32'h5555_5555, 5'd31, 5'd7);
        tick();
        n_cmp++;
        if (rd1_n !== 32'h8000_0001) begin
            n_err++; $display("FAIL wr_x31: got %h want %h", rd1_n, 32'h8000_0001);
        end
        n_cmp++;
        if (rd2_n !== 32'h0000_00A5 || rd2_b !== 32'h0000_00A5) begin
            n_err++; $display("FAIL we_low_no_write: got %h/%h want 000000a5", rd2_n, rd2_b);
        end
    endtask

    task automatic test_x0();
        drive(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
        n_cmp++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0) begin
            n_err++; $display("FAIL x0_no_bypass: got %h/%h want 0/0", rd1_b, rd2_b);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        n_cmp++;
        if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin
            n_err++; $display("FAIL x0_after_write: got %h/%h want 0/0", rd1_b, rd1_n);
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd9, 32'h0000_0001, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd9, 32'h0000_0002, 5'd9, 5'd9);
        n_cmp++;
        if (rd1_b !== 32'h2 || rd2_b !== 32'h2) begin
            n_err++; $display("FAIL bypass_both: got %h/%h want 2/2", rd1_b, rd2_b);
        end
        n_cmp++;
        if (rd1_n !== 32'h1 || rd2_n !== 32'h1) begin
            n_err++; $display("FAIL nobypass_before: got %h/%h want 1/1", rd1_n, rd2_n);
        end
        tick();
        drive(1'b1, 5'd9, 32'h0000_0003, 5'd9, 5'd7);
        n_cmp++;
        if (rd1_n !== 32'h2) begin
            n_err++; $display("FAIL nobypass_after: got %h want %h", rd1_n, 32'h2);
        end
        n_cmp++;
        if (rd1_b !== 32'h3 || rd2_b !== 32'h0000_00A5) begin
            n_err++; $display("FAIL bypass_port1_only: got %h/%h want 3/000000a5", rd1_b, rd2_b);
        end
        drive(1'b1, 5'd9, 32'h0000_0003, 5'd7, 5'd9);
        n_cmp++;
        if (rd1_b !== 32'h0000_00A5 || rd2_b !== 32'h3) begin
            n_err++; $display("FAIL bypass_port2_only: got %h/%h want 000000a5/3", rd1_b, rd2_b);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i), 5'(10 + i - 1), 5'd0);
            if (i > 0) begin
                n_cmp++;
                if (rd1_n !== 32'hA000_0000 + 32'(i - 1)) begin
                    n_err++; $display("FAIL b2b_prev_%0d: got %h want %h", i, rd1_n, 32'hA000_0000 + 32'(i - 1));
                end
            end
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 5'd10, 5'd13);
        n_cmp++;
        if (rd1_b !== 32'hA000_0000 || rd2_b !== 32'hA000_0003) begin
            n_err++; $display("FAIL b2b_final: got %h/%h want a0000000/a0000003", rd1_b, rd2_b);
        end
    endtask

    task automatic test_alu();
        drive(1'b1, 5'd1, 32'd10, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd2, 32'd20, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        alu_control = 4'b0010;
        tick();
        #1;
        n_cmp++;
        if (alu_result !== 32'd30) begin
            n_err++; $display("FAIL alu_add: got %0d want %0d", alu_result, 30);
        end
        alu_control = 4'b0000;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd3, 32'hCAFE_0003, 5'd0, 5'd0);
        tick();
        reset = 1'b0;
        drive(1'b1, 5'd3, 32'h1111_1111, 5'd3, 5'd3);
        n_cmp++;
        if (rd1_b !== 32'hCAFE_0003) begin
            n_err++; $display("FAIL mid_reset_stored_view: got %h want %h", rd1_b, 32'hCAFE_0003);
        end
        tick();
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd2);
        n_cmp++;
        if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin
            n_err++; $display("FAIL mid_reset_x3: got %h/%h want 0/0", rd1_b, rd1_n);
        end
        n_cmp++;
        if (rd2_b !== SP) begin
            n_err++; $display("FAIL mid_reset_x2: got %h want %h", rd2_b, SP);
        end
        drive(1'b1, 5'd4, 32'h0000_0044, 5'd4, 5'd8);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd8);
        n_cmp++;
        if (rd1_b !== 32'h0000_0044 || rd2_b !== 32'h0) begin
            n_err++; $display("FAIL reset_glitch: got %h/%h want 00000044/0", rd1_b, rd2_b);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_back_to_back();
        test_alu();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle RISC-V datapath. Sits directly upstream of the ALU and drives its readData1/readData2 operands.
- Two asynchronous read ports and one synchronous write port. Register x0 is hardwired to zero.
- Optional write-to-read bypass, so a same-cycle read of the register being written returns the new value.

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH registers).
- BYPASS, 1, when 1 a read of the register being written in the same cycle returns writeData; when 0 it returns the stored value.
- SP_RESET, 32'h0000_0000, reset value loaded into x2 (stack pointer); all other registers reset to 0.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted), sampled on rising edge of clock.
- regWrite  input  1  write enable for the write port.
- readRegister1  input  ADDR_WIDTH  index for read port 1 (rs1).
- readRegister2  input  ADDR_WIDTH  index for read port 2 (rs2).
- writeRegister  input  ADDR_WIDTH  index for write port (rd).
- writeData  input  DATA_WIDTH  data to write.
- readData1  output  DATA_WIDTH  contents of readRegister1; feeds ALU readData1.
- readData2  output  DATA_WIDTH  contents of readRegister2; feeds ALU readData2.

Behaviour:
- Storage: array of 2^ADDR_WIDTH registers of DATA_WIDTH bits. x0 is not stored.
- Reset, on a rising edge with reset == 0:
  - all registers are cleared to 0, except x2, which gets SP_RESET;
  - any write presented in that cycle is discarded;
  - reset asserted mid-operation overrides the pending write unconditionally.
- Reset values of outputs are combinational functions of the reset state: after the reset edge, readData of x2 = SP_RESET and of any other index = 0.
- Write, on a rising edge with reset == 1, regWrite == 1 and writeRegister != 0: reg[writeRegister] <= writeData.
  - Writes to index 0 are silently dropped.
  - regWrite == 0 leaves all registers unchanged.
- Read: combinational, zero-cycle latency; readDataN reflects readRegisterN in the same cycle.
  - Index 0 always reads 0, including under bypass.
- Bypass (BYPASS == 1): if regWrite == 1, reset == 1, writeRegister != 0 and readRegisterN == writeRegister, then readDataN = writeData in that cycle.
  - Both ports bypass independently; both may hit the same register.
- Bypass (BYPASS == 0): readDataN returns the stored value; the new value is visible from the cycle after the write edge.
- Bypass is suppressed while reset == 0: outputs show the stored (pre-reset) contents until the reset edge.
- Simultaneous read of the same index on both ports is legal; both outputs are identical.
- No X propagation: every register has a defined value after the first reset edge.
- Width rules:
  - writeData is stored unmodified; no sign or zero extension inside this block.
  - Out-of-range indices are impossible at ADDR_WIDTH = 5. For smaller ADDR_WIDTH, the array is sized 2^ADDR_WIDTH.

Test Plan:
- Reset: hold reset = 0 for 2 clocks with regWrite = 1, writeRegister = 5, writeData = 32'hDEAD_BEEF -> after release, reading x5 gives 0, x2 gives SP_RESET, x31 gives 0.
- Write/read: write x7 = 32'h0000_00A5, then x8 = 32'hFFFF_FFFF on consecutive edges -> readRegister1 = 7 gives 32'h0000_00A5 and readRegister2 = 8 gives 32'hFFFF_FFFF next cycle.
- x0 protection: regWrite = 1, writeRegister = 0, writeData = 32'h1234_5678 -> readData1 for index 0 stays 0 before and after the edge; bypass does not fire.
- Bypass (BYPASS = 1): x9 holds 32'h1; in the same cycle write x9 = 32'h2 with readRegister1 = readRegister2 = 9 -> both readData1 and readData2 = 32'h2 before the edge. With BYPASS = 0 the same stimulus gives 32'h1 before the edge and 32'h2 after.
- Reset mid-operation: after writing x3 = 32'hCAFE_0003, assert reset = 0 for one edge while regWrite = 1 targets x3 -> x3 reads 0 afterwards; reset sampled high, not asserted, between edges has no effect.
- ALU integration: write x1 = 10, x2 = 20; set aluControl = 4'b0010 (add) with rs1 = 1, rs2 = 2 -> aluResult = 30 one clock later.
